// File: rtl/oclib_pkg.sv
// Shared struct types for the CSR and byte-channel interfaces.
//   bc_8b_bidi_s : one direction of a byte channel (data/valid forward, ready backward)
//   csr_32_s     : normalized 32-bit CSR request
//   csr_32_fb_s  : CSR response (ready pulse, error, rdata)
package oclib_pkg;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       ready;
    } bc_8b_bidi_s;

    typedef struct packed {
        logic        read;
        logic        write;
        logic [15:0] toblock;
        logic [3:0]  space;
        logic [31:0] address;
        logic [31:0] wdata;
    } csr_32_s;

    typedef struct packed {
        logic        ready;
        logic        error;
        logic [31:0] rdata;
    } csr_32_fb_s;

endpackage

// File: rtl/oclib_csr_to_bc.sv
// CSR-initiator-side bridge: serializes a csr_32_s request onto a byte channel as a
// request frame and collects the response frame back into csrFb.
//
// Ports:
//   clock  : single clock
//   reset  : synchronous, active-high
//   csr    : request (read, write, toblock, space, address, wdata)
//   csrFb  : response (ready pulse, error, rdata)
//   bcOut  : outgoing request bytes (data/valid) plus ready for bytes arriving on bcIn
//   bcIn   : incoming response bytes (data/valid) plus ready for bytes sent on bcOut
//
// Request frame (MSB first): opcode, {4'h0,space}, toblock[15:0], address[31:0],
// wdata[31:0] (writes only). Response: status byte, then rdata[31:0] for reads.
module oclib_csr_to_bc #(
    parameter type         BcType        = oclib_pkg::bc_8b_bidi_s,
    parameter type         CsrType       = oclib_pkg::csr_32_s,
    parameter type         CsrFbType     = oclib_pkg::csr_32_fb_s,
    parameter int unsigned TimeoutCycles = 32'd1000000
) (
    input  logic     clock,
    input  logic     reset,
    input  CsrType   csr,
    output CsrFbType csrFb,
    output BcType    bcOut,
    input  BcType    bcIn
);

    // Only the oclib struct types are supported.
    if ($bits(BcType) != $bits(oclib_pkg::bc_8b_bidi_s)) begin : g_bad_bc_type
        $error("oclib_csr_to_bc: BcType must be oclib_pkg::bc_8b_bidi_s");
    end
    if ($bits(CsrType) != $bits(oclib_pkg::csr_32_s)) begin : g_bad_csr_type
        $error("oclib_csr_to_bc: CsrType must be oclib_pkg::csr_32_s");
    end
    if ($bits(CsrFbType) != $bits(oclib_pkg::csr_32_fb_s)) begin : g_bad_csr_fb_type
        $error("oclib_csr_to_bc: CsrFbType must be oclib_pkg::csr_32_fb_s");
    end

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StResp,
        StDone
    } state_e;

    state_e      state_q;
    logic [95:0] frame_q;      // request frame, current byte in [95:88]
    logic        valid_q;      // bcOut.valid
    logic        rdy_q;        // bcOut.ready
    logic        is_read_q;
    logic        status_err_q; // status byte of the current response was non-zero
    logic [3:0]  cnt_q;        // bytes sent in SEND, bytes received in RESP
    logic [31:0] rx_q;         // last four received bytes
    logic [31:0] tmo_q;
    logic        fb_ready_q;
    logic        fb_error_q;
    logic [31:0] fb_rdata_q;

    logic       out_xfer;
    logic       in_xfer;
    logic [3:0] last_tx;
    logic [3:0] last_rx;
    logic       tmo_hit;

    assign out_xfer = valid_q && bcIn.ready;
    assign in_xfer  = bcIn.valid && rdy_q;
    assign last_tx  = is_read_q ? 4'd7 : 4'd11;
    assign last_rx  = is_read_q ? 4'd4 : 4'd0;
    // Fires on the cycle the idle count would reach TimeoutCycles.
    assign tmo_hit  = (TimeoutCycles != 0) && (tmo_q == 32'(TimeoutCycles - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            frame_q      <= '0;
            valid_q      <= 1'b0;
            rdy_q        <= 1'b0;
            is_read_q    <= 1'b0;
            status_err_q <= 1'b0;
            cnt_q        <= '0;
            rx_q         <= '0;
            tmo_q        <= '0;
            fb_ready_q   <= 1'b0;
            fb_error_q   <= 1'b0;
            fb_rdata_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Stray bytes are accepted and discarded while idle.
                    rdy_q <= 1'b1;
                    if (csr.read && csr.write) begin
                        state_q    <= StDone;
                        rdy_q      <= 1'b0;
                        fb_ready_q <= 1'b1;
                        fb_error_q <= 1'b1;
                        fb_rdata_q <= '0;
                    end else if (csr.read || csr.write) begin
                        state_q   <= StSend;
                        rdy_q     <= 1'b0;
                        valid_q   <= 1'b1;
                        cnt_q     <= '0;
                        is_read_q <= csr.read;
                        // Reads carry no wdata; zero it so the frame drains to 0.
                        frame_q   <= {(csr.read ? 8'h02 : 8'h01), 4'h0, csr.space,
                                      csr.toblock, csr.address,
                                      (csr.read ? 32'h0 : csr.wdata)};
                    end
                end

                StSend: begin
                    if (out_xfer) begin
                        frame_q <= {frame_q[87:0], 8'h00};
                        if (cnt_q == last_tx) begin
                            state_q      <= StResp;
                            valid_q      <= 1'b0;
                            rdy_q        <= 1'b1;
                            cnt_q        <= '0;
                            tmo_q        <= '0;
                            status_err_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end

                StResp: begin
                    if (in_xfer) begin
                        tmo_q <= '0;
                        rx_q  <= {rx_q[23:0], bcIn.data};
                        if (cnt_q == 4'd0) begin
                            status_err_q <= (bcIn.data != 8'h00);
                        end
                        if (cnt_q == last_rx) begin
                            state_q    <= StDone;
                            rdy_q      <= 1'b0;
                            cnt_q      <= '0;
                            fb_ready_q <= 1'b1;
                            if (is_read_q) begin
                                fb_error_q <= status_err_q;
                                fb_rdata_q <= {rx_q[23:0], bcIn.data};
                            end else begin
                                fb_error_q <= (bcIn.data != 8'h00);
                                fb_rdata_q <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end else if (tmo_hit) begin
                        state_q    <= StDone;
                        rdy_q      <= 1'b0;
                        cnt_q      <= '0;
                        fb_ready_q <= 1'b1;
                        fb_error_q <= 1'b1;
                        fb_rdata_q <= 32'hDEAD_DEAD;
                    end else if (TimeoutCycles != 0) begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end

                StDone: begin
                    // Response was presented for exactly this one cycle.
                    state_q    <= StIdle;
                    rdy_q      <= 1'b1;
                    fb_ready_q <= 1'b0;
                    fb_error_q <= 1'b0;
                    fb_rdata_q <= '0;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        bcOut       = '0;
        bcOut.data  = frame_q[95:88];
        bcOut.valid = valid_q;
        bcOut.ready = rdy_q;
    end

    always_comb begin
        csrFb       = '0;
        csrFb.ready = fb_ready_q;
        csrFb.error = fb_error_q;
        csrFb.rdata = fb_rdata_q;
    end

endmodule

// File: tb/tb_oclib_csr_to_bc.sv
module tb_oclib_csr_to_bc;

    localparam int unsigned Tmo = 100;

    logic clock = 1'b0;
    logic reset = 1'b1;
    oclib_pkg::csr_32_s     csr;
    oclib_pkg::csr_32_fb_s  csr_fb;
    oclib_pkg::bc_8b_bidi_s bc_out;
    oclib_pkg::bc_8b_bidi_s bc_in;

    oclib_csr_to_bc #(
        .TimeoutCycles(Tmo)
    ) dut (
        .clock(clock),
        .reset(reset),
        .csr  (csr),
        .csrFb(csr_fb),
        .bcOut(bc_out),
        .bcIn (bc_in)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clock) cyc = cyc + 1;

    // Reference model state
    logic [7:0]  exp_frame[$];
    logic [7:0]  lit_frame[$];
    logic [7:0]  resp_bytes[$];
    bit          exp_pending   = 1'b0;
    bit          first_pending = 1'b0;
    bit          mon_en        = 1'b0;
    bit          stall_prev    = 1'b0;
    int          exp_mode      = 0;   // 0 normal, 1 timeout, 2 read&write
    logic        exp_error;
    logic [31:0] exp_rdata;
    logic [7:0]  prev_data;
    int req_cyc, first_valid_cyc, last_out_cyc, last_in_cyc;
    int tx_seen = 0;
    int rx_acc  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=%h required=none (cycle %0d)", name, act, cyc);
    endtask

    // Frame built straight from the field layout, MSB first.
    function automatic void model_req(input bit rd, input logic [15:0] tblk,
                                      input logic [3:0] sp, input logic [31:0] ad,
                                      input logic [31:0] wd);
        exp_frame.delete();
        exp_frame.push_back(rd ? 8'h02 : 8'h01);
        exp_frame.push_back({4'h0, sp});
        for (int i = 1; i >= 0; i--) exp_frame.push_back(tblk[8*i +: 8]);
        for (int i = 3; i >= 0; i--) exp_frame.push_back(ad[8*i +: 8]);
        if (!rd) for (int i = 3; i >= 0; i--) exp_frame.push_back(wd[8*i +: 8]);
    endfunction

    // Compare process: checks every byte and every response against the model.
    always @(negedge clock) begin
        if (mon_en) begin
            if (stall_prev) begin
                check("hold_valid", 32'(bc_out.valid), 32'd1);
                check("hold_data", 32'(bc_out.data), 32'(prev_data));
            end
            if (bc_out.valid && first_pending) begin
                check("first_byte_latency", 32'(cyc), 32'(req_cyc + 1));
                first_valid_cyc = cyc;
                first_pending   = 1'b0;
            end
            if (bc_out.valid && bc_in.ready) begin
                tx_seen++;
                if (exp_frame.size() == 0) begin
                    fail_now("extra_tx_byte", 32'(bc_out.data));
                end else begin
                    check("tx_byte", 32'(bc_out.data), 32'(exp_frame.pop_front()));
                    if (exp_frame.size() == 0) last_out_cyc = cyc;
                end
            end
            stall_prev = bc_out.valid && !bc_in.ready;
            prev_data  = bc_out.data;
            if (bc_in.valid && bc_out.ready) begin
                rx_acc++;
                last_in_cyc = cyc;
            end
            if (csr_fb.ready) begin
                if (!exp_pending) begin
                    fail_now("spurious_ready", 32'(csr_fb.rdata));
                end else begin
                    check("fb_error", 32'(csr_fb.error), 32'(exp_error));
                    check("fb_rdata", csr_fb.rdata, exp_rdata);
                    if (exp_mode == 0) begin
                        check("resp_latency", 32'(cyc), 32'(last_in_cyc + 1));
                    end else if (exp_mode == 1) begin
                        check("timeout_latency", 32'(cyc), 32'(last_out_cyc + 1 + int'(Tmo)));
                    end else begin
                        check("illegal_latency_le2",
                              32'((cyc - req_cyc >= 1) && (cyc - req_cyc <= 2)), 32'd1);
                    end
                    exp_pending = 1'b0;
                end
            end
        end
    end

    // bp: 0 = bcIn.ready always 1, 1 = toggles every cycle, 2 = random
    task automatic run_txn(input bit rd, input bit wr, input logic [15:0] tblk,
                           input logic [3:0] sp, input logic [31:0] ad,
                           input logic [31:0] wd, input logic [7:0] status,
                           input logic [31:0] rword, input bit respond, input int bp);
        int base_tx;
        int base_rx;
        int n;
        bit done;
        if (rd && wr) begin
            exp_frame.delete();
            exp_mode  = 2;
            exp_error = 1'b1;
            exp_rdata = 32'h0;
        end else begin
            model_req(rd, tblk, sp, ad, wd);
            if (lit_frame.size() != 0) begin
                exp_frame = lit_frame;
                lit_frame.delete();
            end
            if (!respond) begin
                exp_mode  = 1;
                exp_error = 1'b1;
                exp_rdata = 32'hDEAD_DEAD;
            end else begin
                exp_mode  = 0;
                exp_error = (status != 8'h00);
                exp_rdata = rd ? rword : 32'h0;
            end
        end
        lit_frame.delete();
        resp_bytes.delete();
        resp_bytes.push_back(status);
        if (rd) for (int i = 3; i >= 0; i--) resp_bytes.push_back(rword[8*i +: 8]);
        n       = exp_frame.size();
        base_tx = tx_seen;
        base_rx = rx_acc;
        @(posedge clock); #1;
        bc_in.valid   = 1'b0;
        csr.read      = rd;
        csr.write     = wr;
        csr.toblock   = tblk;
        csr.space     = sp;
        csr.address   = ad;
        csr.wdata     = wd;
        req_cyc       = cyc;
        first_pending = (n != 0);
        exp_pending   = 1'b1;
        done          = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(posedge clock); #1;
            if (csr_fb.ready) begin
                done        = 1'b1;
                csr.read    = 1'b0;
                csr.write   = 1'b0;
                bc_in.valid = 1'b0;
            end else begin
                if (bp == 0)      bc_in.ready = 1'b1;
                else if (bp == 1) bc_in.ready = cyc[0];
                else              bc_in.ready = 1'($urandom_range(0, 1));
                if (respond && !(rd && wr) && (tx_seen - base_tx >= n) &&
                    (rx_acc - base_rx < resp_bytes.size())) begin
                    bc_in.valid = (bp == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
                    bc_in.data  = resp_bytes[rx_acc - base_rx];
                end else begin
                    bc_in.valid = 1'b0;
                    bc_in.data  = 8'($urandom);
                end
            end
        end
        if (!done) begin
            fail_now("ready_never_seen", 32'(tx_seen - base_tx));
            csr.read    = 1'b0;
            csr.write   = 1'b0;
            bc_in.valid = 1'b0;
            exp_pending = 1'b0;
        end
        @(negedge clock); #1;
        check("tx_byte_count", 32'(tx_seen - base_tx), 32'(n));
        if (bp == 0 && n != 0) begin
            check("tx_consecutive", 32'(last_out_cyc - first_valid_cyc), 32'(n - 1));
        end
    endtask

    initial begin
        bit          rd;
        logic [7:0]  st;
        int          base;
        csr         = '0;
        bc_in       = '0;
        bc_in.ready = 1'b1;
        reset       = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_fb_ready", 32'(csr_fb.ready), 32'd0);
        check("rst_fb_error", 32'(csr_fb.error), 32'd0);
        check("rst_fb_rdata", csr_fb.rdata, 32'd0);
        check("rst_bc_valid", 32'(bc_out.valid), 32'd0);
        check("rst_bc_data", 32'(bc_out.data), 32'd0);
        check("rst_bc_ready", 32'(bc_out.ready), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        @(posedge clock); #1;
        check("idle_bc_ready", 32'(bc_out.ready), 32'd1);

        // Directed write, no backpressure
        lit_frame = '{8'h01, 8'h01, 8'h00, 8'h12, 8'h00, 8'h00, 8'h00, 8'h40,
                      8'hA5, 8'hA5, 8'h5A, 8'h5A};
        run_txn(1'b0, 1'b1, 16'h0012, 4'h1, 32'h0000_0040, 32'hA5A5_5A5A,
                8'h00, 32'h0, 1'b1, 0);

        // Directed read
        lit_frame = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10};
        run_txn(1'b1, 1'b0, 16'h0000, 4'h0, 32'h0000_0010, 32'h0,
                8'h00, 32'hDEAD_BEEF, 1'b1, 0);

        // Write with bcIn.ready toggling
        run_txn(1'b0, 1'b1, 16'hBEEF, 4'hC, 32'h1234_5678, 32'h0BAD_F00D,
                8'h00, 32'h0, 1'b1, 1);

        // Error status on a read still returns the data word
        run_txn(1'b1, 1'b0, 16'h0001, 4'h2, 32'h0000_0020, 32'h0,
                8'h03, 32'h1122_3344, 1'b1, 0);

        // Timeout, then a late byte is swallowed in idle, then a normal write
        run_txn(1'b1, 1'b0, 16'h0003, 4'h4, 32'h0000_0080, 32'h0,
                8'h00, 32'h0, 1'b0, 0);
        base        = rx_acc;
        bc_in.valid = 1'b1;
        bc_in.data  = 8'h77;
        repeat (2) @(posedge clock);
        #1;
        bc_in.valid = 1'b0;
        check("late_byte_consumed", 32'(rx_acc - base), 32'd1);
        run_txn(1'b0, 1'b1, 16'h0004, 4'h5, 32'h0000_0100, 32'hCAFE_0001,
                8'h00, 32'h0, 1'b1, 0);

        // read && write together
        run_txn(1'b1, 1'b1, 16'h0005, 4'h6, 32'h0000_0200, 32'h1,
                8'h00, 32'h0, 1'b1, 0);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            rd = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            run_txn(rd, !rd, 16'($urandom), 4'($urandom), $urandom, $urandom,
                    st, $urandom, 1'b1, $urandom_range(0, 2));
            repeat ($urandom_range(0, 3)) @(posedge clock);
        end

        // Reset in the middle of a write frame
        model_req(1'b0, 16'h1234, 4'h2, 32'h0000_0300, 32'h0000_0001);
        exp_mode    = 0;
        exp_error   = 1'b0;
        exp_rdata   = 32'h0;
        base        = tx_seen;
        @(posedge clock); #1;
        bc_in.valid   = 1'b0;
        bc_in.ready   = 1'b1;
        csr.write     = 1'b1;
        csr.read      = 1'b0;
        csr.toblock   = 16'h1234;
        csr.space     = 4'h2;
        csr.address   = 32'h0000_0300;
        csr.wdata     = 32'h0000_0001;
        req_cyc       = cyc;
        first_pending = 1'b1;
        exp_pending   = 1'b1;
        for (int k = 0; k < 100 && (tx_seen - base) < 6; k++) begin
            @(posedge clock); #1;
        end
        check("rst_mid_bytes_sent", 32'(tx_seen - base), 32'd6);
        reset     = 1'b1;
        mon_en    = 1'b0;
        csr.write = 1'b0;
        @(posedge clock); #1;
        check("rst_mid_valid", 32'(bc_out.valid), 32'd0);
        check("rst_mid_fb_ready", 32'(csr_fb.ready), 32'd0);
        check("rst_mid_bc_ready", 32'(bc_out.ready), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        exp_frame.delete();
        exp_pending   = 1'b0;
        first_pending = 1'b0;
        stall_prev    = 1'b0;
        @(posedge clock); #1;
        check("rst_mid_idle_ready", 32'(bc_out.ready), 32'd1);
        check("rst_mid_idle_valid", 32'(bc_out.valid), 32'd0);
        mon_en = 1'b1;

        // Recovery after reset
        run_txn(1'b1, 1'b0, 16'h00AA, 4'h7, 32'h0000_0400, 32'h0,
                8'h00, 32'h5566_7788, 1'b1, 2);

        repeat (3) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
